// File: rtl/jk_register_bank_if.sv
// jk_bank_if: bus bundle for jk_register_bank.
//   master modport (bench / upstream logic): drives en, mode, j, k
//                  (and cnt_clr when JK_CHANGE_CNT_EN is defined),
//                  observes q, qbar, changed, wrap (and change_cnt).
//   slave modport  (the register bank): the mirror image.
//   en      : clock enable, bank holds when 0
//   mode    : 00 JK, 01 D, 10 T, 11 COUNT
//   j, k    : per-bit inputs, meaning depends on mode
//   q, qbar : registered state and its complement
//   changed : one-cycle flag, q changed on the last edge
//   wrap    : one-cycle flag, COUNT mode wrapped on the last edge
// Optional feature macro: JK_CHANGE_CNT_EN adds cnt_clr / change_cnt.
interface jk_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) ();
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             changed;
  logic             wrap;
`ifdef JK_CHANGE_CNT_EN
  logic             cnt_clr;
  logic [CNT_W-1:0] change_cnt;
`endif

  modport master (
    output en, mode, j, k,
`ifdef JK_CHANGE_CNT_EN
    output cnt_clr,
    input  change_cnt,
`endif
    input  q, qbar, changed, wrap
  );

  modport slave (
    input  en, mode, j, k,
`ifdef JK_CHANGE_CNT_EN
    input  cnt_clr,
    output change_cnt,
`endif
    output q, qbar, changed, wrap
  );
endinterface

// File: rtl/jk_register_bank.sv
// jk_register_bank: WIDTH independent JK cells on one clock with a
// synchronous active-high reset and a clock enable. The mode input
// reinterprets j/k as JK, D or T inputs, or runs the whole bank as a
// wrapping up/down counter. Registered changed/wrap flags are provided.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (overrides everything else)
//   bus : jk_bank_if.slave (en, mode, j, k -> q, qbar, changed, wrap)
// Optional feature macro: JK_CHANGE_CNT_EN adds a saturating counter of
// change events (bus.change_cnt) with a synchronous clear (bus.cnt_clr).
module jk_register_bank #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  jk_bank_if.slave    bus
);

  localparam logic [1:0] MODE_JK    = 2'b00;
  localparam logic [1:0] MODE_D     = 2'b01;
  localparam logic [1:0] MODE_T     = 2'b10;
  localparam logic [1:0] MODE_COUNT = 2'b11;

  if (WIDTH < 2 || WIDTH > 32 || CNT_W < 1) begin : g_bad_param
    $error("jk_register_bank: WIDTH must be 2..32 and CNT_W >= 1");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qbar_q;
  logic             changed_q, changed_d;
  logic             wrap_q, wrap_d;

  // Next-state selection. The JK equation q+ = j&~q | ~k&q covers
  // hold/clear/set/toggle per bit. COUNT mode looks only at j[0]/k[0]
  // so unknowns in the other lanes never reach q.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (bus.en) begin
      case (bus.mode)
        MODE_JK: q_d = (bus.j & ~q_q) | (~bus.k & q_q);
        MODE_D:  q_d = bus.j;
        MODE_T:  q_d = q_q ^ bus.j;
        MODE_COUNT: begin
          case ({bus.j[0], bus.k[0]})
            2'b10: begin
              q_d    = q_q + WIDTH'(1);
              wrap_d = &q_q;
            end
            2'b01: begin
              q_d    = q_q - WIDTH'(1);
              wrap_d = ~|q_q;
            end
            2'b11:   q_d = ~q_q;
            default: q_d = q_q;
          endcase
        end
        default: q_d = q_q;
      endcase
    end
    changed_d = (q_d != q_q);
  end

  // qbar is its own flop loaded with ~q_d so it is exact from reset on.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= RST_VAL;
      qbar_q    <= ~RST_VAL;
      changed_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      q_q       <= q_d;
      qbar_q    <= ~q_d;
      changed_q <= changed_d;
      wrap_q    <= wrap_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.qbar    = qbar_q;
  assign bus.changed = changed_q;
  assign bus.wrap    = wrap_q;

`ifdef JK_CHANGE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts edges on which changed is being set; clear beats increment,
  // and the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_clr)
      cnt_d = '0;
    else if (changed_d && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign bus.change_cnt = cnt_q;
`endif

endmodule
